// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register with credit-limited, in-order fetch buffering.
// Optional decode-starvation counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] perf_stall_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0] PCF;
  // One ring holds both in-flight PCs and answered entries:
  // [rdPtr, rspPtr) are buffered, [rspPtr, wrPtr) await their response.
  logic [AW:0] wrPtr, rspPtr, rdPtr;
  logic [AW:0] dropCnt;
  logic [31:0] pcMem    [DEPTH];
  logic [31:0] instrMem [DEPTH];

  logic [AW:0] inFlight, buffered, occupancy, dropNext;
  logic        reqFire, rspPush, rspDiscard, bufNonEmpty, pop;
  logic [31:0] headPc, headInstr;
  logic        unusedTgtLsb;

  assign unusedTgtLsb = ^PCTargetE[1:0];
  assign imem_addr    = PCF;

  always_comb begin
    inFlight       = wrPtr - rspPtr;
    buffered       = rspPtr - rdPtr;
    occupancy      = inFlight + buffered + dropCnt;
    bufNonEmpty    = (buffered != '0);
    imem_req_valid = !rst && !PCSrcE && (occupancy < DEPTH_C);
    reqFire        = imem_req_valid && imem_req_ready;
    rspDiscard     = imem_rsp_valid && (PCSrcE || (dropCnt != '0));
    rspPush        = imem_rsp_valid && !rspDiscard && (inFlight != '0);
    pop            = !FlushD && !StallD && bufNonEmpty;
    headPc         = pcMem[rdPtr[AW-1:0]];
    headInstr      = instrMem[rdPtr[AW-1:0]];
    // Stale responses still owed by memory after a redirect; one arriving now is consumed.
    dropNext       = dropCnt + inFlight;
    if (imem_rsp_valid && (dropNext != '0)) begin
      dropNext = dropNext - PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF     <= RESET_PC;
      wrPtr   <= '0;
      rspPtr  <= '0;
      rdPtr   <= '0;
      dropCnt <= '0;
    end else if (PCSrcE) begin
      PCF     <= {PCTargetE[31:2], 2'b00};
      wrPtr   <= '0;
      rspPtr  <= '0;
      rdPtr   <= '0;
      dropCnt <= dropNext;
    end else begin
      if (reqFire) begin
        PCF   <= PCF + 32'd4;
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (rspPush) begin
        rspPtr <= rspPtr + PTR_ONE;
      end else if (rspDiscard) begin
        dropCnt <= dropCnt - PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reqFire) begin
      pcMem[wrPtr[AW-1:0]] <= PCF;
    end
    if (rspPush) begin
      instrMem[rspPtr[AW-1:0]] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (FlushD || (!StallD && !bufNonEmpty)) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (!StallD) begin
      ValidD   <= 1'b1;
      InstrD   <= headInstr;
      PCD      <= headPc;
      PCPlus4D <= headPc + 32'd4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (!StallD && !FlushD && !bufNonEmpty && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_if_stage.sv
// Self-checking bench for fetch_if_stage: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_if_stage;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] XORK     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] InstrD, PCD, PCPlus4D, perf_stall_cnt;
  logic        ValidD;

  fetch_if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: in-order responses, each request answered after its latency.
  typedef struct { logic [31:0] addr; int due; } memReq_t;
  memReq_t memQ[$];
  int      cyc = 0;
  int      memLat = 1;
  int      lastDue = 0;
  logic    randLat = 1'b0;

  // Reference model: PC queue of outstanding requests and a queue of answered entries.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } bufEnt_t;
  logic [31:0] mPcf;
  logic [31:0] mInfl[$];
  bufEnt_t     mBuf[$];
  int          mDrop;
  logic        mValid;
  logic [31:0] mInstr, mPcd, mPlus4, mPerf;

  logic        curS, curF, curP, curRdy, curRv;
  logic [31:0] curTgt, curRd;

  task automatic modelBubble();
    mValid = 1'b0; mInstr = NOP; mPcd = '0; mPlus4 = '0;
  endtask

  task automatic modelReset();
    mPcf = RESET_PC; mInfl.delete(); mBuf.delete(); mDrop = 0; mPerf = '0;
    modelBubble();
  endtask

  function automatic logic modelReqV(input logic p);
    return ((mInfl.size() + mBuf.size() + mDrop) < int'(DEPTH)) && !p;
  endfunction

  task automatic modelStep();
    int      stale;
    bufEnt_t e;
    logic    reqV, hadBuf;
    reqV   = modelReqV(curP);
    hadBuf = mBuf.size() > 0;
    if (!curS && !curF && !hadBuf && mPerf != 32'hFFFF_FFFF) mPerf++;
    if (curF) modelBubble();
    else if (!curS) begin
      if (hadBuf) begin
        e = mBuf.pop_front();
        mValid = 1'b1; mInstr = e.instr; mPcd = e.pc; mPlus4 = e.pc + 32'd4;
      end else modelBubble();
    end
    if (curP) begin
      stale = mDrop + mInfl.size();
      if (curRv && stale > 0) stale--;
      mDrop = stale;
      mInfl.delete();
      mBuf.delete();
      mPcf = {curTgt[31:2], 2'b00};
    end else begin
      if (curRv) begin
        if (mDrop > 0) mDrop--;
        else if (mInfl.size() > 0) begin
          e.pc = mInfl.pop_front();
          e.instr = curRd;
          mBuf.push_back(e);
        end
      end
      if (reqV && curRdy) begin
        mInfl.push_back(mPcf);
        mPcf = mPcf + 32'd4;
      end
    end
  endtask

  // Called just after a falling edge: drive, settle, compare against the model.
  task automatic apply(input logic s, input logic f, input logic p, input logic [31:0] tgt,
                       input logic rdy);
    logic [31:0] expPerf;
    curS = s; curF = f; curP = p; curTgt = tgt; curRdy = rdy;
    StallD = s; FlushD = f; PCSrcE = p; PCTargetE = tgt; imem_req_ready = rdy;
    curRv = (memQ.size() > 0) && (memQ[0].due == cyc);
    if (curRv) begin
      curRd = memQ[0].addr ^ XORK;
      void'(memQ.pop_front());
    end else curRd = 32'hDEAD_BEEF;
    imem_rsp_valid = curRv;
    imem_rsp_data  = curRd;
    #1;
`ifdef FETCH_PERF_CNT_EN
    expPerf = mPerf;
`else
    expPerf = '0;
`endif
    check("req_valid", imem_req_valid, modelReqV(p));
    check("imem_addr", imem_addr, mPcf);
    check("ValidD", ValidD, mValid);
    check("InstrD", InstrD, mInstr);
    check("PCD", PCD, mPcd);
    check("PCPlus4D", PCPlus4D, mPlus4);
    check("perf_stall_cnt", perf_stall_cnt, expPerf);
  endtask

  task automatic advance();
    int due;
    if (imem_req_valid && curRdy) begin
      due = cyc + memLat;
      if (randLat) memLat = $urandom_range(1, 3);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      memQ.push_back('{addr: imem_addr, due: due});
    end
    modelStep();
    cyc++;
    @(negedge clk);
  endtask

  task automatic resetAll();
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1;
    check("reset_req_valid", imem_req_valid, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_ValidD", ValidD, 1'b0);
    check("reset_InstrD", InstrD, NOP);
    check("reset_PCD", PCD, 32'd0);
    check("reset_PCPlus4D", PCPlus4D, 32'd0);
    check("reset_addr", imem_addr, RESET_PC);
    check("reset_perf", perf_stall_cnt, 32'd0);
    rst = 1'b0;
    memQ.delete();
    lastDue = cyc;
    modelReset();
  endtask

  typedef struct {
    logic        stall, flush, reqV;
    logic [31:0] addr;
    logic        validD;
    logic [31:0] pcd;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mkVec(input logic s, input logic f, input logic rv,
                                 input logic [31:0] a, input logic v, input logic [31:0] pc);
    vec_t r;
    r.stall = s; r.flush = f; r.reqV = rv; r.addr = a; r.validD = v; r.pcd = pc;
    return r;
  endfunction

  initial begin
    logic        found, sawFffc, gotWrap, havePrev;
    logic [31:0] lastPcd;

    // DEPTH=4, memory always ready, 1-cycle latency; stall 6..8, stall+flush at 14.
    tbl[0]  = mkVec(0, 0, 1, 32'd0,  0, 32'd0);
    tbl[1]  = mkVec(0, 0, 1, 32'd4,  0, 32'd0);
    tbl[2]  = mkVec(0, 0, 1, 32'd8,  0, 32'd0);
    tbl[3]  = mkVec(0, 0, 1, 32'd12, 1, 32'd0);
    tbl[4]  = mkVec(0, 0, 1, 32'd16, 1, 32'd4);
    tbl[5]  = mkVec(0, 0, 1, 32'd20, 1, 32'd8);
    tbl[6]  = mkVec(1, 0, 1, 32'd24, 1, 32'd12);
    tbl[7]  = mkVec(1, 0, 1, 32'd28, 1, 32'd12);
    tbl[8]  = mkVec(1, 0, 0, 32'd32, 1, 32'd12);
    tbl[9]  = mkVec(0, 0, 0, 32'd32, 1, 32'd12);
    tbl[10] = mkVec(0, 0, 1, 32'd32, 1, 32'd16);
    tbl[11] = mkVec(0, 0, 1, 32'd36, 1, 32'd20);
    tbl[12] = mkVec(0, 0, 1, 32'd40, 1, 32'd24);
    tbl[13] = mkVec(0, 0, 1, 32'd44, 1, 32'd28);
    tbl[14] = mkVec(1, 1, 1, 32'd48, 1, 32'd32);
    tbl[15] = mkVec(0, 0, 0, 32'd52, 0, 32'd0);
    tbl[16] = mkVec(0, 0, 1, 32'd52, 1, 32'd36);
    tbl[17] = mkVec(0, 0, 1, 32'd56, 1, 32'd40);

    resetAll();
    memLat = 1; randLat = 1'b0;
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].stall, tbl[i].flush, 1'b0, 32'd0, 1'b1);
      check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].reqV);
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_ValidD", i), ValidD, tbl[i].validD);
      check($sformatf("tbl%0d_PCD", i), PCD, tbl[i].pcd);
      check($sformatf("tbl%0d_InstrD", i), InstrD, tbl[i].validD ? (tbl[i].pcd ^ XORK) : NOP);
      check($sformatf("tbl%0d_PCPlus4D", i), PCPlus4D, tbl[i].validD ? (tbl[i].pcd + 32'd4) : 32'd0);
      advance();
    end

    // Redirect with two requests outstanding; both stale responses must vanish.
    resetAll();
    memLat = 3;
    apply(0, 0, 0, 32'd0, 1); advance();
    apply(0, 0, 0, 32'd0, 1); advance();
    apply(0, 1, 1, 32'h0000_0103, 1);
    check("redirect_cycle_no_req", imem_req_valid, 1'b0);
    advance();
    apply(0, 0, 0, 32'd0, 1);
    check("redirect_addr", imem_addr, 32'h0000_0100);
    check("redirect_flushed", ValidD, 1'b0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply(0, 0, 0, 32'd0, 1);
      if (ValidD) begin
        found = 1'b1;
        check("redirect_first_pcd", PCD, 32'h0000_0100);
        check("redirect_first_instr", InstrD, 32'h0000_0100 ^ XORK);
      end
      advance();
    end
    check("redirect_valid_seen", found, 1'b1);

    // PC wrap at the top of the address space.
    apply(0, 1, 1, 32'hFFFF_FFF8, 1); advance();
    sawFffc = 1'b0; gotWrap = 1'b0;
    for (int i = 0; i < 30; i++) begin
      apply(0, 0, 0, 32'd0, 1);
      if (sawFffc) begin
        check("wrap_next_addr", imem_addr, 32'd0);
        sawFffc = 1'b0;
      end
      if (imem_req_valid && imem_addr == 32'hFFFF_FFFC) sawFffc = 1'b1;
      if (ValidD && PCD == 32'hFFFF_FFFC) begin
        check("wrap_pcplus4", PCPlus4D, 32'd0);
        gotWrap = 1'b1;
      end
      advance();
    end
    check("wrap_entry_seen", gotWrap, 1'b1);

    // Ready toggling every other cycle with 3-cycle latency.
    resetAll();
    memLat = 3;
    havePrev = 1'b0; lastPcd = '0;
    for (int i = 0; i < 200; i++) begin
      apply(0, 0, 0, 32'd0, (i % 2) == 0);
      if (ValidD) begin
        if (havePrev) check("order_pcd", PCD, lastPcd + 32'd4);
        lastPcd = PCD;
        havePrev = 1'b1;
      end
      advance();
    end

    // Randomized traffic with variable latency and one reset mid-stream.
    resetAll();
    randLat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic s, f, p, r;
      if (i == 1500) resetAll();
      p = ($urandom_range(0, 19) == 0);
      f = p || ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      apply(s, f, p, $urandom, r);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_if_stage.md
Name: fetch_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined core.
- Owns PCF and drives a valid/ready instruction-memory request port. Buffers in-order responses and presents InstrD/PCD/PCPlus4D to the decode stage, where the immediate extender and control decoder consume InstrD.
- Handles decode stalls, IF/ID flushes and execute-stage PC redirects without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, maximum in-flight plus buffered fetches. Power of two, ≥2.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- PCSrcE  input  1  redirect request from execute (taken branch/jump)
- PCTargetE  input  32  redirect target
- StallD  input  1  hold IF/ID register
- FlushD  input  1  load bubble into IF/ID register
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  fetch address (= PCF)
- imem_rsp_valid  input  1  response data valid; in order, no backpressure
- imem_rsp_data  input  32  fetched instruction word
- InstrD  output  32  instruction to decode
- PCD  output  32  PC of InstrD
- PCPlus4D  output  32  PCD + 4
- ValidD  output  1  InstrD is a real instruction
- perf_stall_cnt  output  32  decode-starvation counter (see Optional Feature)

Behaviour:
- Reset (async) sets:
  - PCF=RESET_PC, imem_req_valid=0
  - ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0
  - buffer empty, drop count 0, perf_stall_cnt=0
- First request may assert in the first cycle after rst deasserts.
- Credit: count = requests in flight + entries buffered. imem_req_valid=1 iff count<DEPTH and PCSrcE=0.
- Request accepted when imem_req_valid && imem_req_ready. PCF <= PCF+4 (mod 2^32, wraps) and the PC is recorded in request order.
- Response: pairs with the oldest in-flight PC and is pushed into the buffer, unless drop count>0. In that case it is discarded and drop count decrements.
- IF/ID update, evaluated each cycle, priority order:
  1. FlushD=1 → bubble (ValidD=0, InstrD=NOP, PCD/PCPlus4D=0). Buffer head is not popped. FlushD overrides StallD.
  2. StallD=1 → hold all IF/ID outputs, no pop.
  3. Buffer non-empty → load head {PC, instr}, PCPlus4D=PC+4, ValidD=1, pop.
  4. Buffer empty → bubble.
- Minimum latency is 2 cycles: accepted at t, response at t+1, ValidD=1 at t+2.
- Redirect (PCSrcE=1):
  - PCF <= {PCTargetE[31:2],2'b00}; bits [1:0] are ignored.
  - Buffer cleared.
  - Drop count <= requests in flight that have not been answered.
  - A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
  - The IF/ID register is not affected by PCSrcE itself; the hazard unit asserts FlushD.
- Simultaneous push and pop in the same cycle is allowed, including at full.
- Buffer never overflows by construction of the credit rule.
- Reset mid-operation discards all in-flight state; later stray responses are not expected from memory.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: perf_stall_cnt increments (saturating at 32'hFFFF_FFFF) each cycle that StallD=0, FlushD=0 and the buffer is empty. These are decode-starvation cycles. Cleared by rst.
- Undefined: perf_stall_cnt tied to 0 and no counter logic.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, imem returns addr^32'hA5A5_0000 → imem_addr 0,4,8,…. First ValidD=1 two cycles after reset with PCD=0 and PCPlus4D=4, then one instruction per cycle in order.
- StallD held 3 cycles mid-stream → IF/ID outputs frozen. imem_req_valid drops once count=DEPTH. After release, the stream resumes with no skipped or duplicated PC.
- PCSrcE=1 with PCTargetE=32'h0000_0103 while 2 requests are in flight, FlushD=1 same cycle → next fetch at 0x100. Both stale responses dropped. First ValidD after redirect has PCD=0x100.
- StallD=1 and FlushD=1 together → bubble loaded (ValidD=0, InstrD=0x0000_0013), buffer head retained and presented next unstalled cycle.
- imem_req_ready toggling every other cycle with 3-cycle response latency → ordering preserved, PCD strictly +4. With FETCH_PERF_CNT_EN, perf_stall_cnt equals the bench-counted empty-buffer cycles.
- PCF=32'hFFFF_FFFC accepted → next imem_addr=0, PCPlus4D of that entry=0.
